// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the CPU, the SA tuning engine, the shared ALU and the arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/ALU side.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 13
);
  logic              cpu_req;
  logic [2:0]        cpu_type;
  logic [1:0]        cpu_mode;
  logic [DATA_W-1:0] cpu_x;
  logic [DATA_W-1:0] cpu_y;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_fout;
  logic [DATA_W-1:0] cpu_pout;

  logic              sa_mul_req;
  logic              sa_div_req;
  logic [DATA_W-1:0] sa_x;
  logic [DATA_W-1:0] sa_y;
  logic              sa_done;
  logic [DATA_W-1:0] sa_fout;

  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [2:0]        alu_type;
  logic [1:0]        alu_mode;
  logic              alu_start;
  logic [DATA_W-1:0] alu_fout;
  logic [DATA_W-1:0] alu_pout;
  logic              alu_done;

  logic [1:0]        owner;
  logic              timeout_err;

  modport slave (
    input  cpu_req, cpu_type, cpu_mode, cpu_x, cpu_y,
    output cpu_done, cpu_fout, cpu_pout,
    input  sa_mul_req, sa_div_req, sa_x, sa_y,
    output sa_done, sa_fout,
    output alu_x, alu_y, alu_type, alu_mode, alu_start,
    input  alu_fout, alu_pout, alu_done,
    output owner, timeout_err
  );

  modport master (
    output cpu_req, cpu_type, cpu_mode, cpu_x, cpu_y,
    input  cpu_done, cpu_fout, cpu_pout,
    output sa_mul_req, sa_div_req, sa_x, sa_y,
    input  sa_done, sa_fout,
    input  alu_x, alu_y, alu_type, alu_mode, alu_start,
    output alu_fout, alu_pout, alu_done,
    input  owner, timeout_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one ALU between the CPU and the SA engine.
// Operands are registered on grant. A hung ALU is aborted after TIMEOUT_CYC cycles.
module alu_share_arbiter #(
  parameter int unsigned DATA_W      = 13,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  localparam logic [1:0]      OWN_NONE = 2'b00;
  localparam logic [1:0]      OWN_CPU  = 2'b01;
  localparam logic [1:0]      OWN_SA   = 2'b10;
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            state;
  logic              last_sa;
  logic [TO_W-1:0]   cnt;
  logic [DATA_W-1:0] alu_x_q, alu_y_q;
  logic [2:0]        alu_type_q;
  logic [1:0]        alu_mode_q;
  logic              alu_start_q;
  logic [1:0]        owner_q;
  logic              timeout_err_q;
  logic              cpu_done_q, sa_done_q;
  logic [DATA_W-1:0] cpu_fout_q, cpu_pout_q, sa_fout_q;

  logic cpu_pend, sa_pend;
  assign cpu_pend = bus.cpu_req;
  assign sa_pend  = bus.sa_mul_req | bus.sa_div_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_sa       <= 1'b1;
      cnt           <= '0;
      alu_x_q       <= '0;
      alu_y_q       <= '0;
      alu_type_q    <= '0;
      alu_mode_q    <= '0;
      alu_start_q   <= 1'b0;
      owner_q       <= OWN_NONE;
      timeout_err_q <= 1'b0;
      cpu_done_q    <= 1'b0;
      sa_done_q     <= 1'b0;
      cpu_fout_q    <= '0;
      cpu_pout_q    <= '0;
      sa_fout_q     <= '0;
    end else begin
      cpu_done_q <= 1'b0;
      sa_done_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          alu_start_q <= 1'b0;
          // CPU wins unless SA is also pending and CPU had the last turn
          if (cpu_pend && (!sa_pend || last_sa)) begin
            alu_x_q     <= bus.cpu_x;
            alu_y_q     <= bus.cpu_y;
            alu_type_q  <= bus.cpu_type;
            alu_mode_q  <= bus.cpu_mode;
            alu_start_q <= 1'b1;
            owner_q     <= OWN_CPU;
            last_sa     <= 1'b0;
            cnt         <= '0;
            state       <= ST_WAIT;
          end else if (sa_pend) begin
            alu_x_q     <= bus.sa_x;
            alu_y_q     <= bus.sa_y;
            alu_type_q  <= bus.sa_mul_req ? 3'b100 : 3'b010;
            alu_mode_q  <= 2'b00;
            alu_start_q <= 1'b1;
            owner_q     <= OWN_SA;
            last_sa     <= 1'b1;
            cnt         <= '0;
            state       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.alu_done) begin
            if (owner_q == OWN_CPU) begin
              cpu_fout_q <= bus.alu_fout;
              cpu_pout_q <= bus.alu_pout;
              cpu_done_q <= 1'b1;
            end else begin
              sa_fout_q  <= bus.alu_fout;
              sa_done_q  <= 1'b1;
            end
            alu_start_q <= 1'b0;
            state       <= ST_RELEASE;
          end else if (cnt == CNT_LAST) begin
            // Abort: hand the owner an all-ones result and flag the error
            if (owner_q == OWN_CPU) begin
              cpu_fout_q <= '1;
              cpu_pout_q <= '1;
              cpu_done_q <= 1'b1;
            end else begin
              sa_fout_q  <= '1;
              sa_done_q  <= 1'b1;
            end
            timeout_err_q <= 1'b1;
            alu_start_q   <= 1'b0;
            state         <= ST_RELEASE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end

        ST_RELEASE: begin
          alu_start_q <= 1'b0;
          owner_q     <= OWN_NONE;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_x       = alu_x_q;
  assign bus.alu_y       = alu_y_q;
  assign bus.alu_type    = alu_type_q;
  assign bus.alu_mode    = alu_mode_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.cpu_done    = cpu_done_q;
  assign bus.cpu_fout    = cpu_fout_q;
  assign bus.cpu_pout    = cpu_pout_q;
  assign bus.sa_done     = sa_done_q;
  assign bus.sa_fout     = sa_fout_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: grant order, latency, result return,
// timeout abort, reset mid-transaction and operand freezing.
module tb_alu_share_arbiter;

  localparam int unsigned DATA_W = 13;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_share_arbiter_if #(.DATA_W(DATA_W)) bus ();

  alu_share_arbiter #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (64),
    .TO_W        (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every drive and sample happens 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int exp_owner;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_type = 3'b000; bus.cpu_mode = 2'b00;
    bus.cpu_x = '0; bus.cpu_y = '0;
    bus.sa_mul_req = 1'b0; bus.sa_div_req = 1'b0; bus.sa_x = '0; bus.sa_y = '0;
    bus.alu_fout = '0; bus.alu_pout = '0; bus.alu_done = 1'b0;
    #1;
    do_reset();

    // Reset state
    check("rst_start", 32'(bus.alu_start), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    check("rst_cpu_fout", 32'(bus.cpu_fout), 32'd0);

    // 1: single CPU multiply, ALU done 4 cycles after start
    bus.cpu_req = 1'b1; bus.cpu_type = 3'b100; bus.cpu_mode = 2'b01;
    bus.cpu_x = 13'd5; bus.cpu_y = 13'd7;
    tick();
    check("t1_start", 32'(bus.alu_start), 32'd1);
    check("t1_owner", 32'(bus.owner), 32'd1);
    check("t1_alu_x", 32'(bus.alu_x), 32'd5);
    check("t1_alu_y", 32'(bus.alu_y), 32'd7);
    check("t1_type", 32'(bus.alu_type), 32'd4);
    check("t1_mode", 32'(bus.alu_mode), 32'd1);
    tick(); tick(); tick();
    check("t1_nodone_early", 32'(bus.cpu_done), 32'd0);
    tick();
    bus.alu_done = 1'b1; bus.alu_fout = 13'd35; bus.alu_pout = 13'd2;
    tick();
    check("t1_cpu_done", 32'(bus.cpu_done), 32'd1);
    check("t1_cpu_fout", 32'(bus.cpu_fout), 32'd35);
    check("t1_cpu_pout", 32'(bus.cpu_pout), 32'd2);
    check("t1_sa_done", 32'(bus.sa_done), 32'd0);
    check("t1_start_off", 32'(bus.alu_start), 32'd0);
    bus.cpu_req = 1'b0; bus.alu_done = 1'b0;
    tick();
    check("t1_done_pulse", 32'(bus.cpu_done), 32'd0);
    check("t1_owner_rel", 32'(bus.owner), 32'd0);
    check("t1_fout_held", 32'(bus.cpu_fout), 32'd35);

    // 2: simultaneous CPU and SA divide after reset -> CPU first, then SA
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_type = 3'b010; bus.cpu_mode = 2'b10;
    bus.cpu_x = 13'd40; bus.cpu_y = 13'd4;
    bus.sa_div_req = 1'b1; bus.sa_x = 13'd100; bus.sa_y = 13'd9;
    tick();
    check("t2_owner_cpu", 32'(bus.owner), 32'd1);
    check("t2_cpu_x", 32'(bus.alu_x), 32'd40);
    bus.alu_done = 1'b1; bus.alu_fout = 13'd10; bus.alu_pout = 13'd0;
    tick();
    check("t2_cpu_done", 32'(bus.cpu_done), 32'd1);
    check("t2_cpu_fout", 32'(bus.cpu_fout), 32'd10);
    check("t2_sa_idle", 32'(bus.sa_done), 32'd0);
    bus.cpu_req = 1'b0; bus.alu_done = 1'b0;
    tick();
    check("t2_gap_start", 32'(bus.alu_start), 32'd0);
    tick();
    check("t2_owner_sa", 32'(bus.owner), 32'd2);
    check("t2_sa_type", 32'(bus.alu_type), 32'd2);
    check("t2_sa_mode", 32'(bus.alu_mode), 32'd0);
    check("t2_sa_x", 32'(bus.alu_x), 32'd100);
    check("t2_sa_y", 32'(bus.alu_y), 32'd9);
    bus.alu_done = 1'b1; bus.alu_fout = 13'd11;
    tick();
    check("t2_sa_done", 32'(bus.sa_done), 32'd1);
    check("t2_sa_fout", 32'(bus.sa_fout), 32'd11);
    check("t2_cpu_untouched", 32'(bus.cpu_fout), 32'd10);
    bus.sa_div_req = 1'b0; bus.alu_done = 1'b0;
    tick();

    // 3: both held high over four transactions; last owner was SA so CPU leads
    bus.cpu_req = 1'b1; bus.cpu_x = 13'd1;
    bus.sa_mul_req = 1'b1; bus.sa_x = 13'd2;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      while (!bus.alu_start && cyc < 10) begin
        tick();
        cyc++;
      end
      exp_owner = (i % 2 == 0) ? 1 : 2;
      check($sformatf("t3_owner_%0d", i), 32'(bus.owner), 32'(exp_owner));
      bus.alu_done = 1'b1; bus.alu_fout = 13'(200 + i);
      tick();
      bus.alu_done = 1'b0;
      if (exp_owner == 1)
        check($sformatf("t3_fout_%0d", i), 32'(bus.cpu_fout), 32'(200 + i));
      else
        check($sformatf("t3_fout_%0d", i), 32'(bus.sa_fout), 32'(200 + i));
    end
    bus.cpu_req = 1'b0; bus.sa_mul_req = 1'b0;
    tick(); tick();
    check("t3_idle", 32'(bus.alu_start), 32'd0);

    // 4: SA multiply, ALU never completes -> timeout after 64 cycles
    bus.sa_mul_req = 1'b1; bus.sa_x = 13'd3; bus.sa_y = 13'd3;
    tick();
    check("t4_start", 32'(bus.alu_start), 32'd1);
    cyc = 0;
    while (!bus.sa_done && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t4_latency", 32'(cyc), 32'd64);
    check("t4_sa_fout", 32'(bus.sa_fout), 32'h1FFF);
    check("t4_terr", 32'(bus.timeout_err), 32'd1);
    check("t4_start_off", 32'(bus.alu_start), 32'd0);
    check("t4_cpu_done", 32'(bus.cpu_done), 32'd0);
    bus.sa_mul_req = 1'b0;
    tick(); tick(); tick();
    check("t4_terr_sticky", 32'(bus.timeout_err), 32'd1);

    // 5: reset during WAIT aborts without a DONE pulse and clears the error
    bus.cpu_req = 1'b1; bus.cpu_x = 13'd9;
    tick();
    check("t5_in_wait", 32'(bus.alu_start), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("t5_start", 32'(bus.alu_start), 32'd0);
    check("t5_owner", 32'(bus.owner), 32'd0);
    check("t5_done", 32'(bus.cpu_done), 32'd0);
    check("t5_terr", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0; bus.cpu_req = 1'b0;
    tick();
    check("t5_no_pulse", 32'(bus.cpu_done), 32'd0);

    // ALU_DONE while idle must be ignored
    bus.alu_done = 1'b1; bus.alu_fout = 13'd77;
    tick();
    check("idle_done_ign", 32'(bus.sa_done), 32'd0);
    check("idle_fout_keep", 32'(bus.sa_fout), 32'd0);
    bus.alu_done = 1'b0;

    // 6: SA mul and div together -> multiply; operands frozen during WAIT
    bus.sa_mul_req = 1'b1; bus.sa_div_req = 1'b1; bus.sa_x = 13'd21; bus.sa_y = 13'd2;
    tick();
    check("t6_type", 32'(bus.alu_type), 32'd4);
    check("t6_x", 32'(bus.alu_x), 32'd21);
    bus.sa_x = 13'd999;
    tick();
    check("t6_x_frozen", 32'(bus.alu_x), 32'd21);
    check("t6_type_frozen", 32'(bus.alu_type), 32'd4);
    bus.alu_done = 1'b1; bus.alu_fout = 13'd42;
    tick();
    check("t6_done", 32'(bus.sa_done), 32'd1);
    check("t6_fout", 32'(bus.sa_fout), 32'd42);
    bus.sa_mul_req = 1'b0; bus.sa_div_req = 1'b0; bus.alu_done = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
